// File: rtl/qlearn_pkg.sv
// Shared Q-learning types, widths and helpers for the Q-table blocks.
package qlearn_pkg;

  localparam int unsigned STATE_WIDTH  = 6;
  localparam int unsigned ACTION_WIDTH = 2;
  localparam int unsigned DATA_WIDTH   = 8;
  localparam int unsigned ADDR_WIDTH   = STATE_WIDTH + ACTION_WIDTH;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_Q,
    ST_RD_N0,
    ST_RD_N1,
    ST_RD_N2,
    ST_RD_N3,
    ST_CALC,
    ST_WR,
    ST_DONE
  } qstate_e;

  // Clamp a value carrying two guard bits into the signed DATA_WIDTH range.
  function automatic logic [DATA_WIDTH-1:0] saturate(input logic signed [DATA_WIDTH+1:0] v);
    logic [2:0] top;
    top = v[DATA_WIDTH+1:DATA_WIDTH-1];
    if (top == 3'b000 || top == 3'b111) return v[DATA_WIDTH-1:0];
    else if (!v[DATA_WIDTH+1])         return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else                               return {1'b1, {(DATA_WIDTH-1){1'b0}}};
  endfunction

  // Q-table address layout: state in the upper bits, action in the lower bits.
  function automatic logic [ADDR_WIDTH-1:0] qaddr(input logic [STATE_WIDTH-1:0]  s,
                                                  input logic [ACTION_WIDTH-1:0] a);
    return {s, a};
  endfunction

endpackage

// File: rtl/qtable_update_ctrl_if.sv
// Request/response and Q-table BRAM signals of the update controller.
interface qtable_update_ctrl_if;
  import qlearn_pkg::*;

  logic                    i_start;
  logic [STATE_WIDTH-1:0]  i_state;
  logic [ACTION_WIDTH-1:0] i_action;
  logic [STATE_WIDTH-1:0]  i_next_state;
  logic [DATA_WIDTH-1:0]   i_reward;
  logic                    o_busy;
  logic                    o_done;
  logic [ACTION_WIDTH-1:0] o_next_action;
  logic [ADDR_WIDTH-1:0]   o_addr_r;
  logic                    o_read_en;
  logic [DATA_WIDTH-1:0]   i_rdata;
  logic [ADDR_WIDTH-1:0]   o_addr_w;
  logic                    o_write_en;
  logic [DATA_WIDTH-1:0]   o_wdata;

  // Controller side.
  modport slave (
    input  i_start, i_state, i_action, i_next_state, i_reward, i_rdata,
    output o_busy, o_done, o_next_action, o_addr_r, o_read_en,
           o_addr_w, o_write_en, o_wdata
  );

  // Agent front end plus Q-table memory side.
  modport master (
    output i_start, i_state, i_action, i_next_state, i_reward, i_rdata,
    input  o_busy, o_done, o_next_action, o_addr_r, o_read_en,
           o_addr_w, o_write_en, o_wdata
  );
endinterface

// File: rtl/qupdate_alu.sv
// Combinational Q-learning update: newQ = sat(Q + ((r + gamma*maxQ - Q) >>> ALPHA_SHIFT)).
module qupdate_alu
  import qlearn_pkg::*;
#(
  parameter int unsigned ALPHA_SHIFT = 2,
  parameter int unsigned GAMMA_SHIFT = 3
) (
  input  logic signed [DATA_WIDTH-1:0] q_i,
  input  logic signed [DATA_WIDTH-1:0] maxq_i,
  input  logic signed [DATA_WIDTH-1:0] r_i,
  output logic        [DATA_WIDTH-1:0] newq_o
);
  localparam int unsigned EW = DATA_WIDTH + 2;

  logic signed [EW-1:0] q_x, m_x, r_x, gm, td, delta, sum;

  // Two guard bits cover the full temporal-difference range.
  always_comb begin
    q_x    = {{2{q_i[DATA_WIDTH-1]}}, q_i};
    m_x    = {{2{maxq_i[DATA_WIDTH-1]}}, maxq_i};
    r_x    = {{2{r_i[DATA_WIDTH-1]}}, r_i};
    gm     = m_x - (m_x >>> GAMMA_SHIFT);
    td     = r_x + gm - q_x;
    delta  = td >>> ALPHA_SHIFT;
    sum    = q_x + delta;
    newq_o = saturate(sum);
  end
endmodule

// File: rtl/qtable_update_ctrl.sv
// Sequences one Q-table read-modify-write per accepted request.
module qtable_update_ctrl
  import qlearn_pkg::*;
#(
  parameter int unsigned ALPHA_SHIFT = 2,
  parameter int unsigned GAMMA_SHIFT = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  qtable_update_ctrl_if.slave  bus
);
  qstate_e                 state_q;
  logic [STATE_WIDTH-1:0]  s_q, sn_q;
  logic [ACTION_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0]   r_q, qsa_q, max_q;
  logic [ACTION_WIDTH-1:0] arg_q;
  logic                    busy_q, done_q, rd_en_q, wr_en_q;
  logic [ADDR_WIDTH-1:0]   addr_r_q, addr_w_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [ACTION_WIDTH-1:0] next_act_q;

  logic [DATA_WIDTH-1:0]   max_d;
  logic [ACTION_WIDTH-1:0] arg_d;
  logic [ACTION_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0]   newq;

  // Running max/argmax over the incoming Q(s',k); strict compare keeps the lowest index on ties.
  always_comb begin
    max_d = max_q;
    arg_d = arg_q;
    unique case (state_q)
      ST_RD_N2: idx = ACTION_WIDTH'(1);
      ST_RD_N3: idx = ACTION_WIDTH'(2);
      ST_CALC:  idx = ACTION_WIDTH'(3);
      default:  idx = '0;
    endcase
    if (state_q == ST_RD_N1 || $signed(bus.i_rdata) > $signed(max_q)) begin
      max_d = bus.i_rdata;
      arg_d = idx;
    end
  end

  qupdate_alu #(
    .ALPHA_SHIFT(ALPHA_SHIFT),
    .GAMMA_SHIFT(GAMMA_SHIFT)
  ) u_alu (
    .q_i    (qsa_q),
    .maxq_i (max_d),
    .r_i    (r_q),
    .newq_o (newq)
  );

  // Controller FSM with registered memory and status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      s_q        <= '0;
      sn_q       <= '0;
      a_q        <= '0;
      r_q        <= '0;
      qsa_q      <= '0;
      max_q      <= '0;
      arg_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      addr_r_q   <= '0;
      addr_w_q   <= '0;
      wdata_q    <= '0;
      next_act_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.i_start) begin
            s_q      <= bus.i_state;
            a_q      <= bus.i_action;
            sn_q     <= bus.i_next_state;
            r_q      <= bus.i_reward;
            addr_r_q <= qaddr(bus.i_state, bus.i_action);
            rd_en_q  <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ST_RD_Q;
          end
        end
        ST_RD_Q: begin
          addr_r_q <= qaddr(sn_q, ACTION_WIDTH'(0));
          state_q  <= ST_RD_N0;
        end
        ST_RD_N0: begin
          qsa_q    <= bus.i_rdata;
          addr_r_q <= qaddr(sn_q, ACTION_WIDTH'(1));
          state_q  <= ST_RD_N1;
        end
        ST_RD_N1: begin
          max_q    <= max_d;
          arg_q    <= arg_d;
          addr_r_q <= qaddr(sn_q, ACTION_WIDTH'(2));
          state_q  <= ST_RD_N2;
        end
        ST_RD_N2: begin
          max_q    <= max_d;
          arg_q    <= arg_d;
          addr_r_q <= qaddr(sn_q, ACTION_WIDTH'(3));
          state_q  <= ST_RD_N3;
        end
        ST_RD_N3: begin
          max_q   <= max_d;
          arg_q   <= arg_d;
          rd_en_q <= 1'b0;
          state_q <= ST_CALC;
        end
        ST_CALC: begin
          max_q    <= max_d;
          arg_q    <= arg_d;
          wdata_q  <= newq;
          addr_w_q <= qaddr(s_q, a_q);
          wr_en_q  <= 1'b1;
          state_q  <= ST_WR;
        end
        ST_WR: begin
          wr_en_q    <= 1'b0;
          done_q     <= 1'b1;
          next_act_q <= arg_q;
          state_q    <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          rd_en_q <= 1'b0;
          wr_en_q <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy        = busy_q;
  assign bus.o_done        = done_q;
  assign bus.o_next_action = next_act_q;
  assign bus.o_addr_r      = addr_r_q;
  assign bus.o_read_en     = rd_en_q;
  assign bus.o_addr_w      = addr_w_q;
  assign bus.o_write_en    = wr_en_q;
  assign bus.o_wdata       = wdata_q;
endmodule
